fu_alu_pipe: RTL and testbench

Parametrised successor to the single-cycle ALU functional unit. It executes RV32I integer ALU ops (OP, OP-IMM, LUI, AUIPC) through a configurable-depth pipeline with a valid/ready issue handshake and CDB backpressure on the output. Each in-flight entry is flushed selectively on branch mispredict by circular ROB-age comparison. It sits between the ALU reservation station/regfile read and the CDB arbiter.

---
 rtl/fu_alu_pipe.sv | 113 +++++++++++
 tb/tb_fu_alu_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_alu_pipe.sv
// fu_alu_pipe: RV32I integer ALU unit with a STAGES-deep result pipeline, CDB backpressure
// and selective flush of in-flight ops younger than a mispredicted branch.
module fu_alu_pipe #(
    parameter int XLEN   = 32,
    parameter int PREG_W = 7,
    parameter int ROB_W  = 5,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   ps1_data,
    input  logic [XLEN-1:0]   ps2_data,
    input  logic [PREG_W-1:0] pd,
    input  logic [ROB_W-1:0]  rob_index,
    input  logic [ROB_W-1:0]  curr_rob_tag,
    input  logic              mispredict,
    input  logic [ROB_W-1:0]  mispredict_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PREG_W-1:0] out_pd,
    output logic [ROB_W-1:0]  out_rob,
    output logic [XLEN-1:0]   out_data
);
    localparam int SH_W = $clog2(XLEN);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic              v;
        logic [PREG_W-1:0] pd;
        logic [ROB_W-1:0]  rob;
        logic [XLEN-1:0]   data;
    } ent_t;

    logic            is_op, is_opi, advance, unused_func7;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] op_b, sra, alu_res, res;
    ent_t            in_e;
    ent_t            src  [STAGES];
    ent_t            st_d [STAGES];
    ent_t            st_q [STAGES];

    assign is_op        = opcode == OPC_OP;
    assign is_opi       = opcode == OPC_OP_IMM;
    assign op_b         = is_op ? ps2_data : imm;
    assign shamt        = op_b[SH_W-1:0];
    assign sra          = $signed(ps1_data) >>> shamt;
    assign unused_func7 = ^{func7[6], func7[4:0]};

    always_comb begin
        case (func3)
            3'b000:  alu_res = (is_op && func7[5]) ? ps1_data - op_b : ps1_data + op_b;
            3'b001:  alu_res = ps1_data << shamt;
            3'b010:  alu_res = XLEN'($signed(ps1_data) < $signed(op_b));
            3'b011:  alu_res = XLEN'(ps1_data < op_b);
            3'b100:  alu_res = ps1_data ^ op_b;
            3'b101:  alu_res = func7[5] ? sra : ps1_data >> shamt;
            3'b110:  alu_res = ps1_data | op_b;
            default: alu_res = ps1_data & op_b;
        endcase
    end

    assign res = (is_op || is_opi)     ? alu_res :
                 (opcode == OPC_LUI)   ? imm :
                 (opcode == OPC_AUIPC) ? pc + imm : '0;

    // Entry lies strictly after the branch and before the ROB tail, modulo ROB size.
    function automatic logic hit(input logic [ROB_W-1:0] rob);
        logic [ROB_W-1:0] d, span;
        d    = rob - mispredict_tag;
        span = curr_rob_tag - mispredict_tag;
        return mispredict && d != '0 && d < span;
    endfunction

    assign advance     = !st_q[STAGES-1].v || out_ready;
    assign issue_ready = advance;
    assign in_e        = (issue_valid && advance) ?
                         ent_t'{v: 1'b1, pd: pd, rob: rob_index, data: res} : '0;
    assign src[0]      = in_e;

    for (genvar s = 1; s < STAGES; s++) begin : g_src
        assign src[s] = st_q[s-1];
    end

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            st_d[i] = advance ? src[i] : st_q[i];
            if (hit(st_d[i].rob)) st_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) st_q[i] <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign out_valid = st_q[STAGES-1].v;
    assign out_pd    = st_q[STAGES-1].pd;
    assign out_rob   = st_q[STAGES-1].rob;
    assign out_data  = st_q[STAGES-1].data;
endmodule

// File: tb/tb_fu_alu_pipe.sv
// tb_fu_alu_pipe: directed scoreboard bench; u3 (STAGES=3) is checked throughout,
// u1 (STAGES=1) shares its inputs and is checked for single-cycle latency.
module tb_fu_alu_pipe;
    localparam logic [6:0] OPI = 7'b0010011, OPR = 7'b0110011, LUI = 7'b0110111, AUIPC = 7'b0010111;

    typedef struct {
        logic [6:0]  pd;
        logic [4:0]  rob;
        logic [31:0] data;
    } exp_t;

    logic        clk = 0, reset = 0, issue_valid = 0, mispredict = 0, out_ready = 1;
    logic [6:0]  opcode = 0, func7 = 0, pd = 0;
    logic [2:0]  func3 = 0;
    logic [31:0] imm = 0, pc = 0, ps1 = 0, ps2 = 0;
    logic [4:0]  rob_index = 0, curr_rob_tag = 0, mispredict_tag = 0;
    logic        ir3, ov3, ir1, ov1;
    logic [6:0]  opd3, opd1;
    logic [4:0]  orob3, orob1;
    logic [31:0] odata3, odata1;
    exp_t        sb [$];
    exp_t        cur;
    bit          last_acc;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    fu_alu_pipe #(.XLEN(32), .PREG_W(7), .ROB_W(5), .STAGES(3)) u3 (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(ir3),
        .opcode(opcode), .func3(func3), .func7(func7), .imm(imm), .pc(pc),
        .ps1_data(ps1), .ps2_data(ps2), .pd(pd), .rob_index(rob_index),
        .curr_rob_tag(curr_rob_tag), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .out_valid(ov3), .out_ready(out_ready), .out_pd(opd3), .out_rob(orob3), .out_data(odata3)
    );

    fu_alu_pipe #(.XLEN(32), .PREG_W(7), .ROB_W(5), .STAGES(1)) u1 (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(ir1),
        .opcode(opcode), .func3(func3), .func7(func7), .imm(imm), .pc(pc),
        .ps1_data(ps1), .ps2_data(ps2), .pd(pd), .rob_index(rob_index),
        .curr_rob_tag(curr_rob_tag), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .out_valid(ov1), .out_ready(out_ready), .out_pd(opd1), .out_rob(orob1), .out_data(odata1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic bit in_win(input logic [4:0] r);
        logic [4:0] d, span;
        d    = r - mispredict_tag;
        span = curr_rob_tag - mispredict_tag;
        return d != 0 && d < span;
    endfunction

    task automatic put(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [6:0] p, input logic [4:0] r, input logic [31:0] want);
        opcode = opc; func3 = f3; func7 = f7; ps1 = a; ps2 = b; imm = im;
        pd = p; rob_index = r; issue_valid = 1;
        cur = '{p, r, want};
    endtask

    task automatic addi(input logic [6:0] p, input logic [4:0] r, input logic [31:0] a,
                        input logic [31:0] im, input logic [31:0] want);
        put(OPI, 3'b000, 7'h00, a, 32'h0, im, p, r, want);
    endtask

    // One clock: score what the coming edge consumes, flushes and accepts, then move to the next negedge.
    task automatic step();
        exp_t e;
        #1;
        if (ov3 && out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", {31'b0, ov3}, 0);
            else begin
                e = sb.pop_front();
                chk("sb_data", odata3, e.data);
                chk("sb_pd", {25'b0, opd3}, {25'b0, e.pd});
                chk("sb_rob", {27'b0, orob3}, {27'b0, e.rob});
            end
        end
        if (mispredict)
            for (int i = sb.size() - 1; i >= 0; i--) if (in_win(sb[i].rob)) sb.delete(i);
        last_acc = issue_valid && ir3;
        if (last_acc && !(mispredict && in_win(rob_index))) sb.push_back(cur);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op_step(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                           input logic [6:0] p, input logic [4:0] r, input logic [31:0] want);
        put(opc, f3, f7, a, b, im, p, r, want);
        step();
    endtask

    task automatic drain();
        issue_valid = 0;
        out_ready = 1;
        for (int i = 0; i < 12 && (sb.size() != 0 || ov3); i++) step();
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, ov3}, 0);
        chk("rst_data", odata3, 0);
        chk("rst_pd", {25'b0, opd3}, 0);
        chk("rst_rob", {27'b0, orob3}, 0);
        reset = 1;
        #1 chk("rst_ready", {31'b0, ir3}, 1);

        addi(5, 3, 10, 5, 15); step();
        chk("s1_valid", {31'b0, ov1}, 1);
        chk("s1_data", odata1, 15);
        chk("s1_pd", {25'b0, opd1}, 5);
        chk("s1_rob", {27'b0, orob1}, 3);
        chk("s3_lat_early", {31'b0, ov3}, 0);
        issue_valid = 0; step();
        chk("s1_drop", {31'b0, ov1}, 0);
        chk("s3_lat_mid", {31'b0, ov3}, 0);
        step();
        chk("s3_lat", {31'b0, ov3}, 1);
        drain();

        addi(6, 4, 10, 5, 15); step();
        op_step(OPR, 3'b000, 7'h20, 30, 12, 0, 7, 5, 18);
        issue_valid = 0; step();
        chk("b2b_first_v", {31'b0, ov3}, 1);
        chk("b2b_first", odata3, 15);
        step();
        chk("b2b_second_v", {31'b0, ov3}, 1);
        chk("b2b_second", odata3, 18);
        step();
        chk("b2b_done", {31'b0, ov3}, 0);
        drain();

        out_ready = 0;
        addi(8, 6, 100, 1, 101); step();
        addi(9, 7, 100, 2, 102); step();
        addi(10, 8, 100, 3, 103); step();
        chk("bp_ready_low", {31'b0, ir3}, 0);
        chk("bp_valid", {31'b0, ov3}, 1);
        addi(11, 9, 100, 4, 104);
        repeat (4) begin
            step();
            chk("bp_ready_held", {31'b0, ir3}, 0);
            chk("bp_data_held", odata3, 101);
        end
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_acc) break;
        end
        chk("bp_issue_accepted", {31'b0, last_acc}, 1);
        drain();

        mispredict_tag = 30; curr_rob_tag = 2; out_ready = 0;
        addi(20, 29, 1, 1, 2); step();
        addi(21, 31, 1, 2, 3); step();
        addi(22, 0, 1, 3, 4); step();
        addi(23, 1, 1, 4, 5); mispredict = 1; step();
        mispredict = 0; issue_valid = 0;
        chk("wrap_keep_v", {31'b0, ov3}, 1);
        chk("wrap_keep_rob", {27'b0, orob3}, 29);
        chk("wrap_keep_data", odata3, 2);
        out_ready = 1;
        repeat (3) begin
            step();
            chk("wrap_quiet", {31'b0, ov3}, 0);
        end
        chk("wrap_sb", sb.size(), 0);

        mispredict_tag = 10; curr_rob_tag = 13;
        addi(30, 10, 0, 7, 7); step();
        addi(31, 11, 0, 8, 8); step();
        addi(32, 12, 0, 9, 9); mispredict = 1; step();
        mispredict = 0; issue_valid = 0;
        chk("flush_branch_v", {31'b0, ov3}, 1);
        chk("flush_branch_rob", {27'b0, orob3}, 10);
        step();
        chk("flush_gone", {31'b0, ov3}, 0);
        step();
        chk("flush_gone_accepted", {31'b0, ov3}, 0);
        drain();

        mispredict_tag = 10; curr_rob_tag = 11;
        addi(33, 10, 0, 1, 1); step();
        addi(34, 11, 0, 2, 2); mispredict = 1; step();
        mispredict = 0;
        drain();

        mispredict_tag = 3; curr_rob_tag = 8; out_ready = 0;
        addi(40, 5, 2, 2, 4); step();
        issue_valid = 0; step(); step();
        chk("stall_full_v", {31'b0, ov3}, 1);
        chk("stall_ready", {31'b0, ir3}, 0);
        mispredict = 1; step();
        mispredict = 0;
        chk("stall_flush_v", {31'b0, ov3}, 0);
        chk("stall_flush_data", odata3, 0);
        chk("stall_flush_pd", {25'b0, opd3}, 0);
        chk("stall_flush_rob", {27'b0, orob3}, 0);
        chk("stall_unblock", {31'b0, ir3}, 1);
        drain();

        op_step(OPR, 3'b101, 7'h20, 32'hF000_0000, 4, 0, 50, 1, 32'hFF00_0000);
        op_step(OPI, 3'b101, 7'h20, 32'hF000_0000, 0, 32'h404, 51, 2, 32'hFF00_0000);
        op_step(OPR, 3'b101, 7'h00, 32'hF000_0000, 4, 0, 52, 3, 32'h0F00_0000);
        op_step(OPI, 3'b011, 7'h00, 10, 0, 20, 53, 4, 1);
        op_step(OPR, 3'b010, 7'h00, 32'hFFFF_FFFF, 1, 0, 54, 5, 1);
        op_step(OPR, 3'b011, 7'h00, 32'hFFFF_FFFF, 1, 0, 55, 6, 0);
        op_step(LUI, 3'b000, 7'h00, 0, 0, 32'h1234_5000, 56, 7, 32'h1234_5000);
        pc = 32'h100;
        op_step(AUIPC, 3'b000, 7'h00, 0, 0, 32'h1000, 57, 8, 32'h1100);
        op_step(OPI, 3'b000, 7'h20, 7, 0, 3, 58, 9, 10);
        op_step(OPR, 3'b001, 7'h00, 1, 32'h21, 0, 59, 10, 2);
        op_step(OPR, 3'b100, 7'h00, 32'hF0F0, 32'hFF00, 0, 60, 11, 32'h0FF0);
        op_step(OPR, 3'b110, 7'h00, 32'hF0F0, 32'hFF00, 0, 61, 12, 32'hFFF0);
        op_step(OPR, 3'b111, 7'h00, 32'hF0F0, 32'hFF00, 0, 62, 13, 32'hF000);
        op_step(OPR, 3'b000, 7'h00, 32'hFFFF_FFFF, 2, 0, 63, 14, 1);
        op_step(7'b1100011, 3'b000, 7'h00, 5, 6, 7, 64, 15, 0);
        drain();

        out_ready = 0;
        addi(70, 20, 1, 1, 2); step();
        addi(71, 21, 1, 2, 3); step();
        issue_valid = 0; step();
        chk("rst_mid_pre", {31'b0, ov3}, 1);
        #2 reset = 0;
        #1;
        chk("rst_mid_v", {31'b0, ov3}, 0);
        chk("rst_mid_data", odata3, 0);
        chk("rst_mid_pd", {25'b0, opd3}, 0);
        chk("rst_mid_rob", {27'b0, orob3}, 0);
        sb.delete();
        @(negedge clk);
        reset = 1; out_ready = 1;
        #1 chk("rst_mid_ready", {31'b0, ir3}, 1);
        step();
        chk("rst_mid_empty", {31'b0, ov3}, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
